motion_alarm_ctrl: RTL
======================

MOTION_ALARM_CTRL -- requirements
Module: motion_alarm_ctrl

Interface
REQ-001 Parameter THRESHOLD, default 20: a PIR reading strictly greater than this value is a hit.
REQ-002 Parameter DEBOUNCE_CYC, default 2: number of consecutive hit samples (1..15) required to qualify a sensor.
REQ-003 Parameter ARM_DELAY, default 2: number of cycles (1..255) spent in ARMING before ARMED.
REQ-004 Parameter ALARM_TIMEOUT, default 50: number of cycles (1..65535) before an alarm auto-clears; used only under REQ-024.
REQ-005 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port turn, input, 1 bit: system enable; 0 forces the system off.
REQ-008 Port stop_alarm, input, 1 bit: user acknowledge; clears an active alarm.
REQ-009 Port pir_sensor_1 / pir_sensor_2 / pir_sensor_3, input, 7 bits each: unsigned PIR readings.
REQ-010 Port alarm, output, 1 bit: high exactly while state = ALARM.
REQ-011 Port armed, output, 1 bit: high exactly while state = ARMED.
REQ-012 Port zone, output, 3 bits: bit i-1 is the latched trigger flag for sensor i.
REQ-013 Port event_count, output, 8 bits: number of ARMED->ALARM transitions since reset.

Function
REQ-014 FSM states are OFF, ARMING, ARMED and ALARM; all outputs are registered.
REQ-015 turn=0 in any state moves the FSM to OFF on the next edge.
- This has priority over every other transition and over stop_alarm.
- In OFF: debounce counters and zone are cleared; event_count is held.
REQ-016 OFF->ARMING when turn=1.
- ARMING counts ARM_DELAY cycles, then moves to ARMED.
- Debounce counters are held at 0 during ARMING.
REQ-017 Per-sensor debounce counter behaviour:
- Increments, saturating at DEBOUNCE_CYC, on each edge where the sensor is a hit.
- Clears to 0 on any non-hit edge.
- The sensor is qualified while its counter equals DEBOUNCE_CYC.
REQ-018 Hit comparison is 7-bit unsigned and strict (>). A reading equal to THRESHOLD is not a hit.
REQ-019 ARMED->ALARM on the edge after any sensor becomes qualified.
- zone loads the qualified bits on that edge.
- event_count increments by 1, saturating at 255, with no wrap.
REQ-020 In ALARM, zone ORs in any newly qualified sensor on each edge; bits already set are never cleared while in ALARM.
REQ-021 ALARM->ARMING when stop_alarm=1 (and turn=1).
- zone clears on the same edge.
- stop_alarm is ignored in every other state.
REQ-022 Latency with defaults: readings above threshold before edge k -> counter reaches 2 at edge k+1 -> alarm=1 after edge k+2.

Reset
REQ-023 rst=1 asynchronously forces:
- state=OFF, alarm=0, armed=0, zone=0, event_count=0, all debounce/arm/timeout counters=0.
- Deassertion mid-operation resumes from OFF on the first edge after release.

Configuration
REQ-024 With macro MOTION_ALARM_TIMEOUT_EN defined, the block instantiates a 16-bit timeout counter.
- The counter clears on entry to ALARM.
- ALARM->ARMING after ALARM_TIMEOUT cycles in ALARM, with zone cleared.
- stop_alarm and turn=0 still take effect earlier.
- Without the macro, ALARM holds until stop_alarm=1 or turn=0, and no timeout counter exists.

Structure
REQ-025 Shared package motion_pkg holds:
- The state enum (OFF, ARMING, ARMED, ALARM).
- The constants PIR_W=7, NUM_SENSORS=3 and EVT_W=8.
REQ-026 Sub-module pir_debounce, instantiated 3 times, contains one threshold compare and one saturating counter, and produces the qualified flag.

Verification
REQ-027 Reset, then turn=1 for 3 cycles -> armed=1 after ARM_DELAY=2 cycles in ARMING, with alarm=0, zone=0 and event_count=0.
REQ-028 Armed; pir_sensor_1=29 and pir_sensor_3=56 for 5 cycles -> alarm=1 two edges after the first sample, zone=3'b101, event_count=1.
REQ-029 Armed; pir_sensor_2=20 (equal to threshold) for 10 cycles, or 25 for 1 cycle only -> alarm stays 0.
REQ-030 Cases during ALARM:
- stop_alarm=1 -> next edge ARMING, zone=0.
- turn=0 together with stop_alarm=1 -> OFF.
- rst pulse -> all outputs 0 immediately.
REQ-031 Cases with MOTION_ALARM_TIMEOUT_EN and ALARM_TIMEOUT=50:
- With the macro: alarm falls after 50 cycles with no stop_alarm.
- Without the macro: alarm is still 1 after 1000 cycles.
- 256 trigger/clear cycles -> event_count=255.

Source files
------------

// File: rtl/motion_pkg.sv
// ============================================================================
// motion_pkg
//   Shared types and constants for the motion alarm controller.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package motion_pkg;

   localparam int PIR_W       = 7;
   localparam int NUM_SENSORS = 3;
   localparam int EVT_W       = 8;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      ARMING = 2'd1,
      ARMED  = 2'd2,
      ALARM  = 2'd3
   } state_t;

   // Event counter sticks at all-ones instead of wrapping.
   function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
      return (v == {EVT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pir_debounce.sv
// ============================================================================
// pir_debounce
//   Strict threshold compare plus saturating hit counter for one PIR sensor.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module pir_debounce
   import motion_pkg::*;
#(
   parameter int THRESHOLD    = 20,
   parameter int DEBOUNCE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [PIR_W-1:0] pir,
   output logic             qualified
);

   localparam logic [PIR_W-1:0] c_THR = PIR_W'(THRESHOLD);
   localparam logic [3:0]       c_SAT = 4'(DEBOUNCE_CYC);

   logic [3:0] r_cnt;
   logic       w_hit;

   assign w_hit = (pir > c_THR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 4'd0;
      end else if (!en || !w_hit) begin
         r_cnt <= 4'd0;
      end else if (r_cnt != c_SAT) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign qualified = (r_cnt == c_SAT);

endmodule

`default_nettype wire

// File: rtl/motion_alarm_ctrl.sv
// ============================================================================
// motion_alarm_ctrl
//   Three-sensor PIR alarm FSM (OFF/ARMING/ARMED/ALARM) with zone latch and
//   event counter. Optional alarm auto-clear: MOTION_ALARM_TIMEOUT_EN.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module motion_alarm_ctrl
   import motion_pkg::*;
#(
   parameter int THRESHOLD     = 20,
   parameter int DEBOUNCE_CYC  = 2,
   parameter int ARM_DELAY     = 2,
   parameter int ALARM_TIMEOUT = 50
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   turn,
   input  logic                   stop_alarm,
   input  logic [PIR_W-1:0]       pir_sensor_1,
   input  logic [PIR_W-1:0]       pir_sensor_2,
   input  logic [PIR_W-1:0]       pir_sensor_3,
   output logic                   alarm,
   output logic                   armed,
   output logic [NUM_SENSORS-1:0] zone,
   output logic [EVT_W-1:0]       event_count
);

   localparam logic [7:0] c_ARM_LAST = 8'(ARM_DELAY - 1);

   state_t                 r_state;
   logic                   r_alarm;
   logic                   r_armed;
   logic [NUM_SENSORS-1:0] r_zone;
   logic [EVT_W-1:0]       r_evt;
   logic [7:0]             r_arm_cnt;

   logic [PIR_W-1:0]       w_pir [NUM_SENSORS];
   logic [NUM_SENSORS-1:0] w_qual;
   logic                   w_deb_en;

   assign w_pir[0] = pir_sensor_1;
   assign w_pir[1] = pir_sensor_2;
   assign w_pir[2] = pir_sensor_3;

   // Debouncers only run while the system is watching for motion.
   assign w_deb_en = turn && ((r_state == ARMED) || (r_state == ALARM));

   for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sensor
      pir_debounce #(
         .THRESHOLD    (THRESHOLD),
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_deb (
         .clk       (clk),
         .rst       (rst),
         .en        (w_deb_en),
         .pir       (w_pir[i]),
         .qualified (w_qual[i])
      );
   end

`ifdef MOTION_ALARM_TIMEOUT_EN
   localparam logic [15:0] c_TO_LAST = 16'(ALARM_TIMEOUT - 1);
   logic [15:0] r_to_cnt;
`else
   // ALARM_TIMEOUT only matters when the auto-clear counter is built in.
   logic w_unused_timeout;
   assign w_unused_timeout = |16'(ALARM_TIMEOUT);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= OFF;
         r_alarm   <= 1'b0;
         r_armed   <= 1'b0;
         r_zone    <= '0;
         r_evt     <= '0;
         r_arm_cnt <= 8'd0;
`ifdef MOTION_ALARM_TIMEOUT_EN
         r_to_cnt  <= 16'd0;
`endif
      end else if (!turn) begin
         r_state   <= OFF;
         r_alarm   <= 1'b0;
         r_armed   <= 1'b0;
         r_zone    <= '0;
         r_arm_cnt <= 8'd0;
      end else begin
         case (r_state)
            OFF: begin
               r_state   <= ARMING;
               r_arm_cnt <= 8'd0;
            end
            ARMING: begin
               if (r_arm_cnt == c_ARM_LAST) begin
                  r_state   <= ARMED;
                  r_armed   <= 1'b1;
                  r_arm_cnt <= 8'd0;
               end else begin
                  r_arm_cnt <= r_arm_cnt + 8'd1;
               end
            end
            ARMED: begin
               if (|w_qual) begin
                  r_state  <= ALARM;
                  r_armed  <= 1'b0;
                  r_alarm  <= 1'b1;
                  r_zone   <= w_qual;
                  r_evt    <= sat_inc(r_evt);
`ifdef MOTION_ALARM_TIMEOUT_EN
                  r_to_cnt <= 16'd0;
`endif
               end
            end
            ALARM: begin
               if (stop_alarm) begin
                  r_state   <= ARMING;
                  r_alarm   <= 1'b0;
                  r_zone    <= '0;
                  r_arm_cnt <= 8'd0;
`ifdef MOTION_ALARM_TIMEOUT_EN
               end else if (r_to_cnt == c_TO_LAST) begin
                  r_state   <= ARMING;
                  r_alarm   <= 1'b0;
                  r_zone    <= '0;
                  r_arm_cnt <= 8'd0;
               end else begin
                  r_zone    <= r_zone | w_qual;
                  r_to_cnt  <= r_to_cnt + 16'd1;
`else
               end else begin
                  r_zone    <= r_zone | w_qual;
`endif
               end
            end
            default: begin
               r_state <= OFF;
               r_alarm <= 1'b0;
               r_armed <= 1'b0;
            end
         endcase
      end
   end

   assign alarm       = r_alarm;
   assign armed       = r_armed;
   assign zone        = r_zone;
   assign event_count = r_evt;

endmodule

`default_nettype wire
